imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side companion to the 16x32 instruction memory: receives a program as a byte
//  stream (valid/ready), packs bytes MSB-first into 32-bit instruction words, drives
//  the memory write port one word per write, and reports the count and a checksum.
//  Sits between the host/debug byte link and the instruction memory write port.
//  The instruction memory is not fetched from during a load.
// PARAMETERS
//  DEPTH   16  words in the target instruction memory
//  ADDR_W  4   memory word-address width; DEPTH == 2**ADDR_W
// PORTS
//  clk           in   1         rising-edge clock
//  rst           in   1         synchronous, active-high reset
//  start         in   1         1-cycle request to begin a load; sampled only in IDLE
//  num_words     in   ADDR_W+1  words to load; sampled with start
//  byte_valid    in   1         byte_data is valid
//  byte_data     in   8         program byte; the first byte of each word is bits [31:24]
//  byte_ready    out  1         loader accepts a byte this cycle
//  mem_we        out  1         write strobe to the instruction memory, 1 cycle per word
//  mem_addr      out  ADDR_W    word address for mem_we
//  mem_wdata     out  32        packed instruction word for mem_we
//  busy          out  1         high in LOAD and WRITE
//  done          out  1         1-cycle pulse when a load finishes
//  err           out  1         sticky: num_words was >DEPTH (clamped); cleared by next accepted start
//  words_written out  ADDR_W+1  words written in the current or last load
//  checksum      out  32        running sum of written words, mod 2^32
// BEHAVIOUR
//  - All outputs are registered. Reset value of every output is 0; FSM goes to IDLE.
//  - FSM states are IDLE, LOAD, WRITE and DONE.
//  - IDLE: byte_ready=0. A start is accepted in IDLE only.
//    - On start, latch N = min(num_words, DEPTH).
//    - err = (num_words > DEPTH).
//    - Clear words_written, checksum and the byte counter.
//    - If N==0, go to DONE; otherwise go to LOAD.
//  - LOAD: byte_ready=1.
//    - A byte is accepted when byte_valid && byte_ready.
//    - It shifts in as word = {word[23:0], byte_data}; the 2-bit byte counter increments.
//    - On acceptance of the 4th byte (counter==3), go to WRITE.
//  - WRITE (exactly 1 cycle): byte_ready=0, mem_we=1.
//    - mem_addr = words_written[ADDR_W-1:0]; mem_wdata = packed word.
//    - At the end of the cycle, words_written += 1 and checksum += mem_wdata.
//    - Go to DONE if words_written+1 == N, else go to LOAD.
//  - DONE (1 cycle): done=1, then go to IDLE.
//    - words_written, checksum and err hold until the next accepted start.
//  - Timing:
//    - mem_we rises on the cycle after the 4th byte is accepted.
//    - Minimum of 5 cycles per word.
//    - done rises on the cycle after the last mem_we.
//  - mem_we is 0 in every state except WRITE. mem_addr/mem_wdata are don't-care while mem_we=0.
//  - start while busy or in DONE is ignored. Bytes offered in IDLE, WRITE or DONE are not
//    consumed (byte_ready=0), and the source must hold them.
//  - byte_valid low mid-word: the partial word and the counter are held indefinitely;
//    there is no timeout.
//  - Address wrap cannot occur: writes are limited to N <= DEPTH, addresses 0..N-1.
//  - rst mid-load: the FSM returns to IDLE next cycle and all outputs go to 0.
//    - Words already written stay in memory; the partial word is discarded.
//  - checksum addition wraps modulo 2^32; no carry out.
// TESTING
//  1. start, num_words=2; bytes 00 22 18 20 21 09 00 0A with byte_valid held high ->
//     mem_we at addr0=0x00221820, then addr1=0x2109000A; done 1 cycle after the 2nd write;
//     words_written=2, checksum=0x212B182A, err=0.
//  2. Same stream with byte_valid low for 3 cycles after byte 2 -> identical writes and
//     checksum; byte_ready stays 1 during the gap; no extra writes.
//  3. num_words=0 -> done 2 cycles after start; no mem_we; words_written=0, checksum=0.
//  4. num_words=20, stream of 16 words 0xFFFFFFFF -> 16 writes to addr 0..15, err=1,
//     words_written=16, checksum=0xFFFFFFF0; byte_ready=0 after the last byte.
//  5. rst asserted after 6 bytes of a 2-word load -> next cycle busy=0, byte_ready=0,
//     mem_we=0, and outputs are 0. A new start with num_words=1 and bytes
//     DE AD BE EF -> addr0=0xDEADBEEF.
//  6. start pulsed during LOAD, and at the DONE cycle -> ignored; N, counts and the
//     FSM sequence are unchanged.

Source files
------------

// File: rtl/imem_loader.sv
// Packs an MSB-first byte stream into 32-bit words and writes them to the instruction memory.
// Five cycles per word minimum (4 byte beats + 1 write); byte_ready drops outside LOAD, so the source must hold its byte.
module imem_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_written,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [23:0]       word_q, word_d;
  logic              byte_ready_q, byte_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   words_written_q, words_written_d;
  logic [31:0]       checksum_q, checksum_d;

  logic              too_many;
  logic [ADDR_W:0]   n_clamp;
  logic [ADDR_W:0]   ww_inc;
  logic              byte_acc;

  assign too_many = (num_words > DEPTH_W);
  assign n_clamp  = too_many ? DEPTH_W : num_words;
  assign ww_inc   = words_written_q + 1'b1;
  assign byte_acc = byte_valid && byte_ready_q;

  always_comb begin
    state_d         = state_q;
    n_d             = n_q;
    cnt_d           = cnt_q;
    word_d          = word_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    err_d           = err_q;
    words_written_d = words_written_q;
    checksum_d      = checksum_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d             = n_clamp;
          err_d           = too_many;
          words_written_d = '0;
          checksum_d      = '0;
          cnt_d           = '0;
          state_d         = (n_clamp == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (byte_acc) begin
          word_d = {word_q[15:0], byte_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d     = WRITE;
            mem_addr_d  = words_written_q[ADDR_W-1:0];
            mem_wdata_d = {word_q, byte_data};
          end
        end
      end
      WRITE: begin
        words_written_d = ww_inc;
        checksum_d      = checksum_q + mem_wdata_q;
        state_d         = (ww_inc == n_q) ? DONE : LOAD;
      end
      default: state_d = IDLE;
    endcase

    // Status strobes are decoded from the next state so they line up with it after the edge.
    byte_ready_d = (state_d == LOAD);
    mem_we_d     = (state_d == WRITE);
    busy_d       = (state_d == LOAD) || (state_d == WRITE);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      n_q             <= '0;
      cnt_q           <= '0;
      word_q          <= '0;
      byte_ready_q    <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      words_written_q <= '0;
      checksum_q      <= '0;
    end else begin
      state_q         <= state_d;
      n_q             <= n_d;
      cnt_q           <= cnt_d;
      word_q          <= word_d;
      byte_ready_q    <= byte_ready_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
      words_written_q <= words_written_d;
      checksum_q      <= checksum_d;
    end
  end

  assign byte_ready    = byte_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = words_written_q;
  assign checksum      = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of load scenarios plus hand-written reset and start-ignore sequences.
module tb_imem_loader;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_written;
  logic [31:0]       checksum;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err),
    .words_written(words_written), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [4:0]       nw;
    int               nsend;
    logic [2:0][31:0] words;
    bit               ones;
    int               gap_after;
    int               gap_len;
    int               exp_ww;
    logic [31:0]      exp_cs;
    bit               exp_err;
  } vec_t;

  wr_t  wq[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[6];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) wq.push_back('{addr: mem_addr, data: mem_wdata, cyc: cyc});
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] nw, input int nsend,
                              input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                              input bit ones, input int gap_after, input int gap_len,
                              input int exp_ww, input logic [31:0] exp_cs, input bit exp_err);
    vec_t v;
    v.nw = nw; v.nsend = nsend;
    v.words[0] = w0; v.words[1] = w1; v.words[2] = w2;
    v.ones = ones; v.gap_after = gap_after; v.gap_len = gap_len;
    v.exp_ww = exp_ww; v.exp_cs = exp_cs; v.exp_err = exp_err;
    return v;
  endfunction

  function automatic logic [31:0] word_of(input vec_t v, input int i);
    if (v.ones) return 32'hFFFF_FFFF;
    if (i < 3) return v.words[i];
    return 32'h0;
  endfunction

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] d);
    int t = 0;
    byte_valid = 1'b1;
    byte_data  = d;
    while (!byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      errors++;
      checks++;
      $display("FAIL byte_timeout: byte_ready never rose for byte 0x%02h", d);
    end
    @(negedge clk);
  endtask

  task automatic do_start(input logic [4:0] nw, output int scyc);
    wq.delete();
    done_cnt = 0;
    start     = 1'b1;
    num_words = nw;
    scyc      = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (done_cnt == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_done_timeout: done not seen within 200 cycles", name);
    end
  endtask

  initial begin
    int   scyc;
    int   k;
    logic [31:0] w;

    rst = 1'b1; start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ww", 32'(words_written), 32'd0);
    chk("rst_cs", checksum, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = mk(5'd2, 2, 32'h0022_1820, 32'h2109_000A, 32'h0, 1'b0, -1, 0, 2, 32'h212B_182A, 1'b0);
    vecs[1] = mk(5'd2, 2, 32'h0022_1820, 32'h2109_000A, 32'h0, 1'b0, 2, 3, 2, 32'h212B_182A, 1'b0);
    vecs[2] = mk(5'd0, 0, 32'h0, 32'h0, 32'h0, 1'b0, -1, 0, 0, 32'h0, 1'b0);
    vecs[3] = mk(5'd20, 16, 32'h0, 32'h0, 32'h0, 1'b1, -1, 0, 16, 32'hFFFF_FFF0, 1'b1);
    vecs[4] = mk(5'd1, 1, 32'h1234_5678, 32'h0, 32'h0, 1'b0, -1, 0, 1, 32'h1234_5678, 1'b0);
    vecs[5] = mk(5'd3, 3, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 1'b0, 5, 2, 3, 32'h0000_0001, 1'b0);

    for (int v = 0; v < 6; v++) begin
      do_start(vecs[v].nw, scyc);
      k = 0;
      for (int i = 0; i < vecs[v].nsend; i++) begin
        w = word_of(vecs[v], i);
        for (int b = 0; b < 4; b++) begin
          if (k == vecs[v].gap_after) begin
            byte_valid = 1'b0;
            for (int g = 0; g < vecs[v].gap_len; g++) begin
              chk($sformatf("v%0d_gap_ready", v), 32'(byte_ready), 32'd1);
              @(negedge clk);
            end
          end
          send_byte(w[31-8*b -: 8]);
          k++;
        end
      end
      byte_valid = 1'b0;
      wait_done($sformatf("v%0d", v));
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_nwrites", v), 32'(wq.size()), 32'(vecs[v].exp_ww));
      for (int i = 0; i < wq.size() && i < vecs[v].exp_ww; i++) begin
        chk($sformatf("v%0d_addr%0d", v, i), 32'(wq[i].addr), 32'(i));
        chk($sformatf("v%0d_data%0d", v, i), wq[i].data, word_of(vecs[v], i));
        if (i > 0 && vecs[v].gap_len == 0)
          chk($sformatf("v%0d_spacing%0d", v, i), 32'(wq[i].cyc - wq[i-1].cyc), 32'd5);
      end
      if (vecs[v].exp_ww > 0 && wq.size() > 0)
        chk($sformatf("v%0d_done_after_we", v), 32'(done_cyc - wq[wq.size()-1].cyc), 32'd1);
      else
        chk($sformatf("v%0d_done_latency_ok", v), 32'(done_cyc - scyc >= 1 && done_cyc - scyc <= 2), 32'd1);
      chk($sformatf("v%0d_done_pulses", v), 32'(done_cnt), 32'd1);
      chk($sformatf("v%0d_ww", v), 32'(words_written), 32'(vecs[v].exp_ww));
      chk($sformatf("v%0d_cs", v), checksum, vecs[v].exp_cs);
      chk($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_idle_ready", v), 32'(byte_ready), 32'd0);
      chk($sformatf("v%0d_idle_busy", v), 32'(busy), 32'd0);
    end

    // Reset in the middle of the second word of a two-word load.
    do_start(5'd2, scyc);
    send_byte(8'h00); send_byte(8'h22); send_byte(8'h18); send_byte(8'h20);
    send_byte(8'h21); send_byte(8'h09);
    byte_valid = 1'b0;
    chk("mid_ww_before_rst", 32'(words_written), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(byte_ready), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_ww", 32'(words_written), 32'd0);
    chk("mid_rst_cs", checksum, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    do_start(5'd1, scyc);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    byte_valid = 1'b0;
    wait_done("post_rst");
    repeat (2) @(negedge clk);
    chk("post_rst_nwrites", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) begin
      chk("post_rst_addr", 32'(wq[0].addr), 32'd0);
      chk("post_rst_data", wq[0].data, 32'hDEAD_BEEF);
    end
    chk("post_rst_cs", checksum, 32'hDEAD_BEEF);

    // start pulses during LOAD and on the DONE cycle must be ignored.
    do_start(5'd2, scyc);
    send_byte(8'h00); send_byte(8'h22);
    byte_valid = 1'b0;
    start = 1'b1; num_words = 5'd5;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h18); send_byte(8'h20); send_byte(8'h21); send_byte(8'h09);
    send_byte(8'h00); send_byte(8'h0A);
    byte_valid = 1'b0;
    chk("ign_we_cycle", 32'(mem_we), 32'd1);
    @(negedge clk);
    chk("ign_done_cycle", 32'(done), 32'd1);
    start = 1'b1; num_words = 5'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ign_busy", 32'(busy), 32'd0);
    chk("ign_nwrites", 32'(wq.size()), 32'd2);
    chk("ign_done_pulses", 32'(done_cnt), 32'd1);
    chk("ign_ww", 32'(words_written), 32'd2);
    chk("ign_cs", checksum, 32'h212B_182A);
    if (wq.size() == 2) begin
      chk("ign_data0", wq[0].data, 32'h0022_1820);
      chk("ign_data1", wq[1].data, 32'h2109_000A);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
